// File: rtl/mem_responder.sv
// Word-addressed memory slave with programmable wait states, request/ready
// handshake and alignment/range fault detection.
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Ready,
    output logic        Fault,
    output logic        Busy
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    // state | meaning: IDLE accept request | WAIT count wait states | RESP pulse Ready
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    wr_q;
    logic                    fault_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem [DEPTH];

    logic                    req_fault;
    logic                    access;
    logic                    acc_wr;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_data;

    assign req_fault = (Address[1:0] != 2'b00) || ((Address >> (ADDR_WIDTH + 2)) != 32'd0);

    // With no wait states the access happens on the accepting edge, so it
    // must use the live request fields rather than the latched copies.
    always_comb begin
        acc_wr   = wr_q;
        acc_idx  = idx_q;
        acc_data = wdata_q;
        access   = 1'b0;
        if (state == IDLE) begin
            acc_wr   = Wr;
            acc_idx  = Address[ADDR_WIDTH+1:2];
            acc_data = Datain;
            access   = NO_WAIT && Req && !req_fault;
        end else if (state == WAIT) begin
            access   = (cnt == 4'd0);
        end
        if (Reset) begin
            access = 1'b0;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (access) begin
            if (acc_wr) begin
                mem[acc_idx] <= acc_data;
                rdata_q      <= acc_data;
            end else begin
                rdata_q      <= mem[acc_idx];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            Dataout <= 32'd0;
            Ready   <= 1'b0;
            Fault   <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            Ready <= 1'b0;
            Fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        wr_q    <= Wr;
                        idx_q   <= Address[ADDR_WIDTH+1:2];
                        wdata_q <= Datain;
                        fault_q <= req_fault;
                        Busy    <= 1'b1;
                        if (req_fault || NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    Ready   <= 1'b1;
                    Fault   <= fault_q;
                    Dataout <= fault_q ? 32'd0 : rdata_q;
                    Busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
